// File: rtl/supersaw_tdm.sv
// Supersaw oscillator: VOICES detuned sawtooth phase accumulators summed into
// one unsigned sample per accepted sample_tick, using a single shared adder
// stepped across the voices one per clock.
module supersaw_tdm #(
    parameter int VOICES   = 8,
    parameter int ACC_W    = 32,
    parameter int SAW_W    = 11,
    parameter int OUT_W    = 16,
    parameter int BASE_INC = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_tick,
    input  logic [15:0]      pitch,
    input  logic [7:0]       detune,
    input  logic             sync,
    output logic [OUT_W-1:0] audio_out,
    output logic             audio_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int IDX_W = $clog2(VOICES);
    localparam int SUM_W = SAW_W + IDX_W;
    localparam int PAD_W = OUT_W - SUM_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VOICES - 1);

    // state   | meaning
    // S_IDLE  | waiting for sample_tick
    // S_RUN   | one voice updated and accumulated per cycle
    // S_DONE  | publish the sum, strobe audio_valid; accepts a new tick
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [ACC_W-1:0]   base_inc_q, base_inc_d;
    logic [ACC_W-1:0]   step_q, step_d;
    logic [ACC_W-1:0]   spread_q, spread_d;
    logic               sync_q, sync_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [OUT_W-1:0]   audio_out_q, audio_out_d;
    logic               valid_q, valid_d;
    logic               overrun_q, overrun_d;

    logic [ACC_W-1:0]   phase_q [VOICES];
    logic               phase_we;
    logic [ACC_W-1:0]   phase_rd;
    logic [ACC_W-1:0]   inc;
    logic [ACC_W-1:0]   phase_new;
    logic [SAW_W-1:0]   saw;
    logic               accept;

    // Next-state, shared adder datapath and output staging.
    // The per-voice detune term i*detune is built incrementally in spread_q so
    // no multiplier is needed.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        base_inc_d  = base_inc_q;
        step_d      = step_q;
        spread_d    = spread_q;
        sync_d      = sync_q;
        sum_d       = sum_q;
        audio_out_d = audio_out_q;
        valid_d     = 1'b0;
        overrun_d   = overrun_q;
        phase_we    = 1'b0;

        phase_rd  = phase_q[idx_q];
        inc       = base_inc_q + spread_q;
        phase_new = sync_q ? inc : (phase_rd + inc);
        saw       = phase_new[ACC_W-1 -: SAW_W];
        accept    = sample_tick && (state_q != S_RUN);

        case (state_q)
            S_RUN: begin
                phase_we = 1'b1;
                sum_d    = sum_q + SUM_W'(saw);
                idx_d    = idx_q + IDX_W'(1);
                spread_d = spread_q + step_q;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end
                if (sample_tick) begin
                    overrun_d = 1'b1;
                end
            end
            S_DONE: begin
                audio_out_d = OUT_W'(sum_q) << PAD_W;
                valid_d     = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A tick in DONE starts the next sweep while the finished sum is
        // still being published from sum_q in the same cycle.
        if (accept) begin
            base_inc_d = ACC_W'({pitch, 8'd0}) + ACC_W'(BASE_INC);
            step_d     = ACC_W'({detune, 8'd0});
            spread_d   = '0;
            sync_d     = sync;
            sum_d      = '0;
            idx_d      = '0;
            state_d    = S_RUN;
        end
    end

    // Control and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            base_inc_q  <= '0;
            step_q      <= '0;
            spread_q    <= '0;
            sync_q      <= 1'b0;
            sum_q       <= '0;
            audio_out_q <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            base_inc_q  <= base_inc_d;
            step_q      <= step_d;
            spread_q    <= spread_d;
            sync_q      <= sync_d;
            sum_q       <= sum_d;
            audio_out_q <= audio_out_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    // Phase storage: one read and one write per cycle; reset clears every
    // voice so an aborted sweep leaves no partial phases behind.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < VOICES; i++) begin
                phase_q[i] <= '0;
            end
        end else if (phase_we) begin
            phase_q[idx_q] <= phase_new;
        end
    end

    assign audio_out   = audio_out_q;
    assign audio_valid = valid_q;
    assign busy        = (state_q == S_RUN);
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_supersaw_tdm.sv
// Scoreboard bench for supersaw_tdm: a per-sample arithmetic model of the
// voices pushes expected samples; an independent monitor checks each strobe.
module tb_supersaw_tdm;

    logic        clk;
    logic        reset;
    logic        sample_tick;
    logic [15:0] pitch;
    logic [7:0]  detune;
    logic        sync;
    logic [15:0] audio_out;
    logic        audio_valid;
    logic        busy;
    logic        overrun;

    supersaw_tdm dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .pitch       (pitch),
        .detune      (detune),
        .sync        (sync),
        .audio_out   (audio_out),
        .audio_valid (audio_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q [$];
    logic [15:0] hold_exp = '0;
    logic [31:0] mphase [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: each voice advances by its own increment, and the
    // sample is the sum of the top 11 phase bits, shifted to 16 bits.
    task automatic model_tick(input logic [15:0] p, input logic [7:0] d, input logic s);
        int unsigned sum;
        logic [31:0] inc;
        sum = 0;
        for (int i = 0; i < 8; i++) begin
            inc = {8'd0, p, 8'd0} + 32'd50000 + 32'(i) * {16'd0, d, 8'd0};
            mphase[i] = s ? inc : mphase[i] + inc;
            sum += mphase[i] >> 21;
        end
        exp_q.push_back(16'(sum * 4));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mphase[i] = '0;
    endtask

    // Monitor: pops one expectation per strobe, and checks that audio_out
    // holds its value between strobes.
    always @(negedge clk) begin
        if (reset) begin
            hold_exp = '0;
        end else if (audio_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got audio_out %0d with no sample outstanding at %0t", audio_out, $time);
            end else begin
                hold_exp = exp_q.pop_front();
                check("audio_out", {16'd0, audio_out}, {16'd0, hold_exp});
            end
        end else begin
            check("audio_hold", {16'd0, audio_out}, {16'd0, hold_exp});
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    // Presents a tick for one cycle; returns 1 ns after the accepting edge
    // with the inputs scrambled to prove only latched values are used.
    task automatic send_tick(input logic [15:0] p, input logic [7:0] d, input logic s);
        @(posedge clk);
        #1;
        pitch = p; detune = d; sync = s; sample_tick = 1'b1;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        pitch  = 16'($urandom);
        detune = 8'($urandom);
        sync   = 1'($urandom);
    endtask

    // Single sample with latency and busy-width checks.
    task automatic do_sample(input logic [15:0] p, input logic [7:0] d, input logic s);
        int lat;
        int busy_cnt;
        model_tick(p, d, s);
        send_tick(p, d, s);
        busy_cnt = busy ? 1 : 0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (audio_valid) begin
                lat = k;
                break;
            end
            if (busy) busy_cnt++;
        end
        check("latency", 32'(lat), 32'd9);
        check("busy_cycles", 32'(busy_cnt), 32'd8);
    endtask

    task automatic wait_valid(input string name);
        int got;
        got = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (audio_valid) begin
                got = 1;
                break;
            end
        end
        check(name, 32'(got), 32'd1);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; sample_tick = 1'b0; pitch = '0; detune = '0; sync = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_audio_out", {16'd0, audio_out}, 32'd0);
        check("rst_valid", {31'd0, audio_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_overrun", {31'd0, overrun}, 32'd0);

        // Defaults: 128, then 256, then hard sync back to 128.
        do_sample(16'h8000, 8'd0, 1'b0);
        check("phase0_first", dut.phase_q[0], 32'h0080C350);
        do_sample(16'h8000, 8'd0, 1'b0);
        check("phase5_second", dut.phase_q[5], 32'h010186A0);
        do_sample(16'h8000, 8'd0, 1'b1);

        // Detune spread.
        do_reset();
        do_sample(16'h0000, 8'hFF, 1'b0);
        check("phase7_detune", dut.phase_q[7], 32'd506960);
        for (int n = 0; n < 5; n++) do_sample(16'h0000, 8'hFF, 1'b0);
        check("phase7_model", dut.phase_q[7], mphase[7]);

        // Wrap: full pitch with random spread and occasional hard sync.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            do_sample(16'hFFFF, 8'($urandom), ($urandom_range(0, 15) == 0));
        end
        for (int i = 0; i < 8; i++) check("phase_wrap_model", dut.phase_q[i], mphase[i]);

        // Fully random inputs with random idle gaps.
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            do_sample(16'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0));
        end

        // Overrun: second tick 3 cycles into the sweep is ignored.
        check("overrun_before", {31'd0, overrun}, 32'd0);
        model_tick(16'h1234, 8'h21, 1'b0);
        send_tick(16'h1234, 8'h21, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        pitch = 16'hFFFF; detune = 8'hFF; sync = 1'b1; sample_tick = 1'b1;
        @(posedge clk);
        #1 sample_tick = 1'b0;
        wait_valid("overrun_pair_valid");
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("overrun_set", {31'd0, overrun}, 32'd1);
        check("overrun_queue", 32'(exp_q.size()), 32'd0);
        do_sample(16'h0400, 8'h10, 1'b0);
        check("overrun_sticky", {31'd0, overrun}, 32'd1);

        // Reset mid-sweep: no strobe, all state cleared.
        send_tick(16'h8000, 8'h55, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_overrun", {31'd0, overrun}, 32'd0);
        check("midrst_audio", {16'd0, audio_out}, 32'd0);
        for (int i = 0; i < 8; i++) check("midrst_phase", dut.phase_q[i], 32'd0);
        do_sample(16'h8000, 8'd0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("final_audio", {16'd0, audio_out}, 32'd128);
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
